sdf_stage_auto: RTL and testbench
=================================

// Module: sdf_stage_auto
// PURPOSE
//  Self-sequencing radix-2 single-path delay-feedback (SDF) NTT/INTT stage with a streaming valid/ready input.
//  The frame counter, butterfly mux selects, twiddle address and drain (flush) sequencing are all generated inside the block.
//  Delay depth, data width and modulus are parametrised.
//  Stages are cascaded with LOG_DEPTH = log2(N)-1 down to 0 to build an N-point pipelined transform.
// PARAMETERS
//  DATA_WIDTH  16    coefficient width; every value carried is < MODULO.
//  LOG_DEPTH   3     delay-line depth D = 2**LOG_DEPTH; frame length F = 2*D.
//  MODULO      7681  prime modulus Q; Q < 2**DATA_WIDTH.
//  TW_AW       8     twiddle ROM address width; TW_AW >= LOG_DEPTH.
// PORTS
//  clk        in   1           clock
//  rst_n      in   1           asynchronous reset, active-low
//  mode       in   1           0 = NTT (Cooley-Tukey), 1 = INTT (Gentleman-Sande); captured per frame
//  in_valid   in   1           input sample valid
//  in_ready   out  1           stage can accept a sample
//  in_data    in   DATA_WIDTH  input coefficient
//  tw_addr    out  TW_AW       twiddle address; combinational from the frame counter
//  tw_data    in   DATA_WIDTH  twiddle value; combinational ROM, sampled together with in_data
//  flush      in   1           level request to drain the delay line at a frame boundary
//  out_valid  out  1           output sample valid; downstream is always ready
//  out_data   out  DATA_WIDTH  output coefficient
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, frame counter cnt=0, delay line all 0, state RUN, mode_q=0.
//  - Accept: in_valid && in_ready at a rising edge. In RUN, in_ready=1; in FLUSH, in_ready=0.
//  - cnt is LOG_DEPTH+1 bits and advances only on accept. It wraps F-1 -> 0.
//  - mode_q <= mode on an accept with cnt==0; mode_q is held for the whole frame.
//  - The delay line is a D-entry shift register that shifts only on accept or on a flush cycle. head = oldest entry.
//  - Phase A (cnt[MSB]=0): out_data <= head; in_data is pushed into the delay line.
//  - Phase B (cnt[MSB]=1): a = head, b = in_data, w = tw_data.
//      NTT:  t = b*w mod Q;  out_data <= (a+t) mod Q;  push (a-t) mod Q.
//      INTT: out_data <= (a+b) mod Q;  push ((a-b) mod Q)*w mod Q.
//  - tw_addr = cnt[LOG_DEPTH-1:0] << (TW_AW-LOG_DEPTH).
//  - Modular arithmetic:
//      add: s = a+b computed in DATA_WIDTH+1 bits; subtract Q if s >= Q.
//      sub: a-b if a >= b, otherwise a-b+Q.
//      mul: full 2*DATA_WIDTH-bit product, then % Q.
//      All results lie in [0, Q).
//  - Timing: out_valid=1 exactly in the cycle after each accept or flush cycle, otherwise 0.
//      out_data holds its value while out_valid=0.
//  - Frame order: phase-A outputs of frame f are the pushed differences of frame f-1. Frame latency is D samples.
//  - FSM RUN/FLUSH:
//      RUN -> FLUSH when flush=1, cnt==0 and no accept occurs that cycle. Data wins; a held flush is taken on the next idle cycle.
//      flush asserted mid-frame is ignored until cnt==0.
//      In FLUSH: D cycles; each cycle emits head (out_valid=1) and pushes 0. Afterwards return to RUN with cnt=0.
//  - Gaps in in_valid stall the stage with no loss of data or ordering.
//  - Reset asserted mid-frame or mid-flush clears everything immediately; no partial output is emitted afterwards.
// TESTING (DATA_WIDTH=16, LOG_DEPTH=1, Q=7681)
//  1. Reset: hold rst_n=0 -> out_valid=0, out_data=0, in_ready=1. Release, first flush -> outputs 0,0.
//  2. NTT frame: in 1,2,3,4 with tw=1 -> phase-B outputs 4,6. Then flush -> outputs 7679,7679.
//  3. INTT: a=5, b=2, w=3 -> out1=7; after flush the pushed term gives out2=9.
//  4. Wrap: NTT a=7680, b=1, w=1 -> out1=0, out2=7679. Product check: b=w=7680 -> t=1.
//  5. Stalls and boundaries:
//      random in_valid gaps -> output identical to the gap-free run.
//      flush mid-frame -> ignored until frame end.
//      flush together with in_valid at cnt==0 -> sample accepted, flush taken next idle cycle.
//  6. Mode toggled mid-frame -> takes effect only from the next frame.
//      rst_n pulsed during FLUSH -> out_valid drops at once; delay line reads 0.

Source files
------------

// File: rtl/sdf_stage_auto.sv
// Radix-2 single-path delay-feedback NTT/INTT stage with an internal frame counter,
// twiddle addressing and drain sequencing; streaming valid/ready input.
module sdf_stage_auto #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG_DEPTH  = 3,
    parameter int MODULO     = 7681,
    parameter int TW_AW      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [TW_AW-1:0]      tw_addr,
    input  logic [DATA_WIDTH-1:0] tw_data,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int D  = 1 << LOG_DEPTH;
    localparam int CW = LOG_DEPTH + 1;
    localparam logic [DATA_WIDTH-1:0]   QD = DATA_WIDTH'(MODULO);
    localparam logic [DATA_WIDTH:0]     Q1 = (DATA_WIDTH + 1)'(MODULO);
    localparam logic [2*DATA_WIDTH-1:0] Q2 = (2 * DATA_WIDTH)'(MODULO);

    typedef enum logic {RUN, FLUSH} state_t;

    function automatic logic [DATA_WIDTH-1:0] mod_add(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= Q1) s = s - Q1;
        return DATA_WIDTH'(s);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] mod_sub(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        return (a >= b) ? (a - b) : (a - b + QD);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] mod_mul(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic [2*DATA_WIDTH-1:0] p;
        p = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
        return DATA_WIDTH'(p % Q2);
    endfunction

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         fcnt_q, fcnt_d;
    logic                  mode_q, mode_d;
    logic [DATA_WIDTH-1:0] dl_q [D];
    logic [DATA_WIDTH-1:0] dl_d [D];
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic                  accept;
    logic                  shift;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] diff;
    logic [DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0] push_val;

    assign in_ready  = (state_q == RUN);
    assign accept    = in_valid && in_ready;
    assign head      = dl_q[0];
    assign tw_addr   = TW_AW'(cnt_q[LOG_DEPTH-1:0]) << (TW_AW - LOG_DEPTH);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // One shared multiplier: NTT multiplies the incoming sample, INTT the difference.
    assign diff = mod_sub(head, in_data);
    assign prod = mod_mul(mode_q ? diff : in_data, tw_data);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fcnt_d      = fcnt_q;
        mode_d      = mode_q;
        dl_d        = dl_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        shift       = 1'b0;
        push_val    = '0;

        if (state_q == RUN) begin
            if (accept) begin
                cnt_d       = cnt_q + CW'(1);
                shift       = 1'b1;
                out_valid_d = 1'b1;
                if (cnt_q == '0) mode_d = mode;
                if (!cnt_q[CW-1]) begin
                    out_data_d = head;
                    push_val   = in_data;
                end else if (!mode_q) begin
                    out_data_d = mod_add(head, prod);
                    push_val   = mod_sub(head, prod);
                end else begin
                    out_data_d = mod_add(head, in_data);
                    push_val   = prod;
                end
            end else if (flush && cnt_q == '0) begin
                state_d = FLUSH;
                fcnt_d  = '0;
            end
        end else begin
            shift       = 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = head;
            fcnt_d      = fcnt_q + CW'(1);
            if (fcnt_q == CW'(D - 1)) begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end

        if (shift) begin
            for (int unsigned i = 0; i + 1 < D; i++) dl_d[i] = dl_q[i+1];
            dl_d[D-1] = push_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            fcnt_q      <= '0;
            mode_q      <= 1'b0;
            dl_q        <= '{default: '0};
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fcnt_q      <= fcnt_d;
            mode_q      <= mode_d;
            dl_q        <= dl_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_sdf_stage_auto.sv
// Directed bench for sdf_stage_auto with D=2 (4-sample frames), Q=7681:
// cycle-accurate vector table plus gap, flush and reset sequences.
module tb_sdf_stage_auto;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [7:0]  tw_addr;
    logic [15:0] tw_data;
    logic        flush;
    logic        out_valid;
    logic [15:0] out_data;

    sdf_stage_auto #(
        .DATA_WIDTH(16),
        .LOG_DEPTH (1),
        .MODULO    (7681),
        .TW_AW     (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .tw_addr  (tw_addr),
        .tw_data  (tw_data),
        .flush    (flush),
        .out_valid(out_valid),
        .out_data (out_data)
    );

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic [15:0] w;
        logic        m;
        logic        f;
        logic        ev;
        logic [15:0] ed;
        logic        er;
    } vec_t;

    vec_t        tbl[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] cap[$];
    logic        collect  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "timeout");
    end

    always @(posedge clk) begin
        #1;
        if (collect && out_valid) cap.push_back(out_data);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [15:0] w,
                         input logic m, input logic f);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        tw_data  = w;
        mode     = m;
        flush    = f;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic v, input int d, input int w, input logic m, input logic f,
                       input logic ev, input int ed, input logic er);
        vec_t x;
        x.v = v; x.d = 16'(d); x.w = 16'(w); x.m = m; x.f = f;
        x.ev = ev; x.ed = 16'(ed); x.er = er;
        tbl.push_back(x);
    endtask

    logic [15:0] gd[4];
    logic [15:0] gexp[6];

    initial begin
        rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0; tw_data = '0; flush = 1'b0;

        // first flush after reset
        add(0,0,0,0,1, 0,0,0);    add(0,0,0,0,0, 1,0,0);    add(0,0,0,0,0, 1,0,1);
        // NTT 1,2,3,4 tw=1, then flush
        add(1,1,1,0,0, 1,0,1);    add(1,2,1,0,0, 1,0,1);
        add(1,3,1,0,0, 1,4,1);    add(1,4,1,0,0, 1,6,1);
        add(0,0,0,0,0, 0,6,1);    add(0,0,0,0,1, 0,6,0);
        add(0,0,0,0,0, 1,7679,0); add(0,0,0,0,0, 1,7679,1);
        // INTT a=5,b=2,w=3 and a=7,b=1,w=3
        add(1,5,0,1,0, 1,0,1);    add(1,7,0,1,0, 1,0,1);
        add(1,2,3,1,0, 1,7,1);    add(1,1,3,1,0, 1,8,1);
        add(0,0,0,0,1, 0,8,0);    add(0,0,0,0,0, 1,9,0);    add(0,0,0,0,0, 1,18,1);
        // wrap: a=7680,b=1,w=1; product 7680*7680 -> 1
        add(1,7680,1,0,0, 1,0,1); add(1,7680,1,0,0, 1,0,1);
        add(1,1,1,0,0, 1,0,1);    add(1,7680,7680,0,0, 1,0,1);
        add(0,0,0,0,1, 0,0,0);    add(0,0,0,0,0, 1,7679,0); add(0,0,0,0,0, 1,7679,1);
        // NTT with non-trivial twiddles
        add(1,10,0,0,0, 1,0,1);   add(1,20,0,0,0, 1,0,1);
        add(1,3,100,0,0, 1,310,1); add(1,5,2000,0,0, 1,2339,1);
        add(0,0,0,0,1, 0,2339,0); add(0,0,0,0,0, 1,7391,0); add(0,0,0,0,0, 1,5382,1);
        // flush held mid-frame with gaps: ignored until the frame ends
        add(1,1,1,0,0, 1,0,1);    add(0,0,0,0,1, 0,0,1);
        add(1,2,1,0,1, 1,0,1);    add(0,0,0,0,1, 0,0,1);
        add(1,3,1,0,1, 1,4,1);    add(1,4,1,0,1, 1,6,1);
        // flush with in_valid at cnt==0: sample wins, flush taken on next idle cycle
        add(1,0,0,0,1, 1,7679,1); add(1,0,0,0,1, 1,7679,1);
        add(1,0,1,0,1, 1,0,1);    add(1,0,1,0,1, 1,0,1);
        add(0,0,0,0,1, 0,0,0);
        add(1,55,0,0,0, 1,0,0);   add(1,55,0,0,0, 1,0,1);
        add(1,55,0,0,0, 1,0,1);   add(1,66,0,0,0, 1,0,1);
        add(1,1,1,0,0, 1,56,1);   add(1,0,5,0,0, 1,66,1);
        add(0,0,0,0,1, 0,66,0);   add(0,0,0,0,0, 1,54,0);   add(0,0,0,0,0, 1,66,1);
        // mode toggled mid-frame only applies from the next frame
        add(1,5,0,1,0, 1,0,1);    add(1,7,0,0,0, 1,0,1);
        add(1,2,3,0,0, 1,7,1);    add(1,1,3,0,0, 1,8,1);
        add(1,0,0,0,0, 1,9,1);    add(1,0,0,0,0, 1,18,1);
        add(1,3,2,1,0, 1,6,1);    add(1,1,1,1,0, 1,1,1);
        add(0,0,0,0,1, 0,1,0);    add(0,0,0,0,0, 1,7675,0); add(0,0,0,0,0, 1,7680,1);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_tw_addr", int'(tw_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].w, tbl[i].m, tbl[i].f);
            chk($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(tbl[i].ev));
            chk($sformatf("vec%0d_out_data", i), int'(out_data), int'(tbl[i].ed));
            chk($sformatf("vec%0d_in_ready", i), int'(in_ready), int'(tbl[i].er));
        end

        // random input gaps with flush held after the first sample
        gd[0] = 16'd1; gd[1] = 16'd2; gd[2] = 16'd3; gd[3] = 16'd4;
        gexp[0] = 16'd0; gexp[1] = 16'd0; gexp[2] = 16'd4;
        gexp[3] = 16'd6; gexp[4] = 16'd7679; gexp[5] = 16'd7679;
        drive(0, 0, 0, 0, 0);
        cap.delete();
        collect = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int g;
            g = (i == 0) ? 0 : int'($urandom_range(3, 1));
            repeat (g) drive(0, 0, 0, 0, (i > 0));
            drive(1, gd[i], 16'd1, 0, (i > 0));
            chk("gap_tw_addr", int'(tw_addr), ((i + 1) % 2) * 128);
        end
        begin
            int n;
            n = 0;
            do begin
                drive(0, 0, 0, 0, 1);
                n++;
            end while (in_ready && n < 20);
            chk("gap_flush_entered", int'(in_ready), 0);
            n = 0;
            do begin
                drive(0, 0, 0, 0, 0);
                n++;
            end while (!in_ready && n < 20);
            chk("gap_flush_done", int'(in_ready), 1);
        end
        drive(0, 0, 0, 0, 0);
        collect = 1'b0;
        chk("gap_out_count", cap.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("gap_out%0d", i), (i < cap.size()) ? int'(cap[i]) : -1, int'(gexp[i]));
        end

        // reset pulsed mid-flush
        drive(1, 1, 1, 0, 0);
        drive(1, 2, 1, 0, 0);
        drive(1, 3, 1, 0, 0);
        drive(1, 4, 1, 0, 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        chk("rstflush_pre_valid", int'(out_valid), 1);
        chk("rstflush_pre_data", int'(out_data), 7679);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstflush_out_valid", int'(out_valid), 0);
        chk("rstflush_out_data", int'(out_data), 0);
        chk("rstflush_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 1);
        chk("rstflush_reenter", int'(in_ready), 0);
        drive(0, 0, 0, 0, 0);
        chk("rstflush_drain0_valid", int'(out_valid), 1);
        chk("rstflush_drain0_data", int'(out_data), 0);
        drive(0, 0, 0, 0, 0);
        chk("rstflush_drain1_valid", int'(out_valid), 1);
        chk("rstflush_drain1_data", int'(out_data), 0);
        drive(0, 0, 0, 0, 0);
        chk("rstflush_idle_valid", int'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
